// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: drives a six-digit multiplexed 7-segment display from
// BCD digits. It has a prescaled scan, a frame-aligned snapshot, leading-zero
// blanking and registered outputs.
module bcd_display_scanner #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] ten_thousands,
  input  logic [3:0] hundred_thousands,
  input  logic       freeze,
  input  logic       blank_lz,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic [2:0] digit_sel,
  output logic       frame_done
);

  localparam int unsigned CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'd5;
  localparam logic [5:0]    AN_OFF   = 6'b111111;
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  logic [CW-1:0]   r_count;
  logic [2:0]      r_idx;
  logic [5:0][3:0] r_snap;
  logic            r_load_first;

  logic            w_tick;
  logic            w_wrap;
  logic [5:0][3:0] w_din;
  logic [5:0]      w_blank;
  logic [3:0]      w_digit;
  logic            w_dark;
  logic [6:0]      w_seg;

  assign w_din  = {hundred_thousands, ten_thousands, thousands, hundreds, tens, ones};
  assign w_tick = en && (r_count == CNT_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Prescaler and scan index; both hold while en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_count <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else if (en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Snapshot: loaded on the first edge after reset, then only at frame wraps when not frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap       <= '0;
      r_load_first <= 1'b1;
    end else begin
      r_load_first <= 1'b0;
      if (r_load_first || (w_wrap && !freeze)) begin
        r_snap <= w_din;
      end
    end
  end

  // Leading-zero blanking: digit k dark when it and all higher digits are zero.
  always_comb begin
    logic v_upper_zero;
    w_blank      = '0;
    v_upper_zero = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      v_upper_zero = v_upper_zero && (r_snap[k] == 4'd0);
      w_blank[k]   = blank_lz && v_upper_zero;
    end
  end

  // Select the digit currently being scanned and whether it is blanked.
  always_comb begin
    w_digit = 4'd0;
    w_dark  = 1'b1;
    case (r_idx)
      3'd0: begin w_digit = r_snap[0]; w_dark = 1'b0;       end
      3'd1: begin w_digit = r_snap[1]; w_dark = w_blank[1]; end
      3'd2: begin w_digit = r_snap[2]; w_dark = w_blank[2]; end
      3'd3: begin w_digit = r_snap[3]; w_dark = w_blank[3]; end
      3'd4: begin w_digit = r_snap[4]; w_dark = w_blank[4]; end
      3'd5: begin w_digit = r_snap[5]; w_dark = w_blank[5]; end
      default: begin w_digit = 4'd0; w_dark = 1'b1; end
    endcase
  end

  // BCD to active-low segments {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  always_comb begin
    w_seg = 7'b0111111;
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  // Registered display outputs and the end-of-frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      digit_sel  <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_wrap;
      digit_sel  <= r_idx;
      if (!en || w_dark) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end else begin
        an  <= ~(6'b000001 << r_idx);
        seg <= w_seg;
      end
    end
  end

endmodule
